// File: rtl/inst_fifo.sv
// inst_fifo: instruction queue between fetch and decode.
//
// Accepts up to two fetched instructions per cycle (lane 1 and lane 2) and
// presents the two oldest entries to decode every cycle in first-word-fall-
// through form.
//
// Handshake: a write lane is taken when its enable is high, lane 1 is also
// enabled (lane 2 alone is never taken), fifo_full is low and flush is low.
// A read lane pops when its enable is high, its read_valid is high and, for
// lane 2, lane 1 also pops in the same cycle. Reads and writes in one cycle
// both take effect. flush overrides everything and empties the queue.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   flush                     discard all entries
//   write_en_1/2              fetch lane valids
//   write_addr_1/2            PC of each fetch lane
//   write_data_1/2            instruction word of each fetch lane
//   read_en_1/2               decode consumes head / head+1
//   read_addr_1/2             PC at head / head+1 (0 when not valid)
//   read_data_1/2             instruction at head / head+1 (0 when not valid)
//   read_valid_1/2            head / head+1 entry present
//   fifo_full                 fewer than two free entries
//   fifo_empty                no entries held
module inst_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        write_en_1,
  input  logic        write_en_2,
  input  logic [31:0] write_addr_1,
  input  logic [31:0] write_addr_2,
  input  logic [31:0] write_data_1,
  input  logic [31:0] write_data_2,
  input  logic        read_en_1,
  input  logic        read_en_2,
  output logic [31:0] read_addr_1,
  output logic [31:0] read_addr_2,
  output logic [31:0] read_data_1,
  output logic [31:0] read_data_2,
  output logic        read_valid_1,
  output logic        read_valid_2,
  output logic        fifo_full,
  output logic        fifo_empty
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ZERO   = '0;
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   CNT_TWO    = (AW+1)'(2);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH - 1);

  logic [31:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;
  logic [AW:0]   wr_cnt;
  logic [AW:0]   rd_cnt;

  assign head_p1 = head + PTR_ONE;
  assign tail_p1 = tail + PTR_ONE;

  // Status comes from the registered count only, so fifo_full never depends
  // on same-cycle reads: a write seen while full is dropped even if a pop
  // frees room in that cycle.
  assign read_valid_1 = (count >= CNT_ONE);
  assign read_valid_2 = (count >= CNT_TWO);
  assign fifo_empty   = (count == CNT_ZERO);
  assign fifo_full    = (count >= FULL_LEVEL);

  // Number of entries written this cycle.
  always_comb begin
    wr_cnt = CNT_ZERO;
    if (!flush && !fifo_full && write_en_1) begin
      wr_cnt = write_en_2 ? CNT_TWO : CNT_ONE;
    end
  end

  // Number of entries popped this cycle: in order, and only what is valid.
  always_comb begin
    rd_cnt = CNT_ZERO;
    if (read_en_1 && read_valid_1) begin
      rd_cnt = (read_en_2 && read_valid_2) ? CNT_TWO : CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + rd_cnt[AW-1:0];
      tail  <= tail + wr_cnt[AW-1:0];
      count <= count + wr_cnt - rd_cnt;
    end
  end

  // Storage is not reset; the valid flags mask stale contents.
  always_ff @(posedge clk) begin
    if (wr_cnt != CNT_ZERO) begin
      addr_mem[tail] <= write_addr_1;
      data_mem[tail] <= write_data_1;
    end
    if (wr_cnt == CNT_TWO) begin
      addr_mem[tail_p1] <= write_addr_2;
      data_mem[tail_p1] <= write_data_2;
    end
  end

  assign read_addr_1 = read_valid_1 ? addr_mem[head]    : 32'h0;
  assign read_data_1 = read_valid_1 ? data_mem[head]    : 32'h0;
  assign read_addr_2 = read_valid_2 ? addr_mem[head_p1] : 32'h0;
  assign read_data_2 = read_valid_2 ? data_mem[head_p1] : 32'h0;

endmodule

// File: tb/tb_inst_fifo.sv
// Bench for inst_fifo: a queue-based reference model checked against the
// DUT every falling edge, plus directed scenarios with literal expectations.
module tb_inst_fifo;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        write_en_1, write_en_2;
  logic [31:0] write_addr_1, write_addr_2;
  logic [31:0] write_data_1, write_data_2;
  logic        read_en_1, read_en_2;
  logic [31:0] read_addr_1, read_addr_2;
  logic [31:0] read_data_1, read_data_2;
  logic        read_valid_1, read_valid_2;
  logic        fifo_full, fifo_empty;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference contents, oldest first: {addr, data}.
  logic [63:0] exp_q[$];

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .write_en_1   (write_en_1),
    .write_en_2   (write_en_2),
    .write_addr_1 (write_addr_1),
    .write_addr_2 (write_addr_2),
    .write_data_1 (write_data_1),
    .write_data_2 (write_data_2),
    .read_en_1    (read_en_1),
    .read_en_2    (read_en_2),
    .read_addr_1  (read_addr_1),
    .read_addr_2  (read_addr_2),
    .read_data_1  (read_data_1),
    .read_data_2  (read_data_2),
    .read_valid_1 (read_valid_1),
    .read_valid_2 (read_valid_2),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] addr);
    return ~addr ^ 32'h0000_5a5a;
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      int  pops;
      bit  was_full;
      was_full = (exp_q.size() >= DEPTH - 1);
      pops = 0;
      if (read_en_1 && exp_q.size() >= 1) begin
        pops = 1;
        if (read_en_2 && exp_q.size() >= 2) pops = 2;
      end
      for (int i = 0; i < pops; i++) void'(exp_q.pop_front());
      if (!was_full && write_en_1) begin
        exp_q.push_back({write_addr_1, write_data_1});
        if (write_en_2) exp_q.push_back({write_addr_2, write_data_2});
      end
    end
  end

  // Outputs depend only on registered state, so the falling edge is a
  // stable point to compare them.
  always @(negedge clk) begin
    int n;
    n = exp_q.size();
    chk("model_valid_1", {31'b0, read_valid_1}, {31'b0, n >= 1});
    chk("model_valid_2", {31'b0, read_valid_2}, {31'b0, n >= 2});
    chk("model_empty",   {31'b0, fifo_empty},   {31'b0, n == 0});
    chk("model_full",    {31'b0, fifo_full},    {31'b0, n >= DEPTH - 1});
    chk("model_addr_1", read_addr_1, (n >= 1) ? exp_q[0][63:32] : 32'h0);
    chk("model_data_1", read_data_1, (n >= 1) ? exp_q[0][31:0]  : 32'h0);
    chk("model_addr_2", read_addr_2, (n >= 2) ? exp_q[1][63:32] : 32'h0);
    chk("model_data_2", read_data_2, (n >= 2) ? exp_q[1][31:0]  : 32'h0);
  end

  // ---------------- driver ----------------
  // Apply one cycle of stimulus, then return at the following falling edge,
  // where outputs reflect the rising edge that consumed it.
  task automatic drive(input logic we1, input logic we2,
                       input logic [31:0] a1, input logic [31:0] a2,
                       input logic re1, input logic re2, input logic fl);
    write_en_1   = we1;
    write_en_2   = we2;
    write_addr_1 = a1;
    write_addr_2 = a2;
    write_data_1 = data_of(a1);
    write_data_2 = data_of(a2);
    read_en_1    = re1;
    read_en_2    = re2;
    flush        = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] base;
    rst = 1'b1;
    flush = 1'b0;
    write_en_1 = 1'b0; write_en_2 = 1'b0;
    write_addr_1 = '0; write_addr_2 = '0;
    write_data_1 = '0; write_data_2 = '0;
    read_en_1 = 1'b0; read_en_2 = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_empty",   {31'b0, fifo_empty},   32'd1);
    chk("reset_full",    {31'b0, fifo_full},    32'd0);
    chk("reset_valid_1", {31'b0, read_valid_1}, 32'd0);
    chk("reset_addr_1",  read_addr_1,           32'h0);
    rst = 1'b1;
    idle();

    // Dual write, visible right after the edge.
    drive(1'b1, 1'b1, 32'hbfc00000, 32'hbfc00004, 1'b0, 1'b0, 1'b0);
    chk("dual_valid_1", {31'b0, read_valid_1}, 32'd1);
    chk("dual_valid_2", {31'b0, read_valid_2}, 32'd1);
    chk("dual_addr_1",  read_addr_1, 32'hbfc00000);
    chk("dual_addr_2",  read_addr_2, 32'hbfc00004);
    chk("dual_data_1",  read_data_1, data_of(32'hbfc00000));
    chk("dual_empty",   {31'b0, fifo_empty}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("dual_pop_empty", {31'b0, fifo_empty}, 32'd1);

    // count=1 with both read enables pops one; lane 2 write alone ignored.
    drive(1'b1, 1'b0, 32'h00000100, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("one_valid_2", {31'b0, read_valid_2}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("over_read_empty", {31'b0, fifo_empty}, 32'd1);
    drive(1'b0, 1'b1, 32'h0, 32'h00000200, 1'b0, 1'b0, 1'b0);
    chk("we2_only_empty", {31'b0, fifo_empty}, 32'd1);
    // read_en_2 alone pops nothing.
    drive(1'b1, 1'b1, 32'h00000300, 32'h00000304, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("re2_only_addr_1", read_addr_1, 32'h00000300);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);

    // Fill with 8 dual writes: entry k has address 0x1000 + 4k.
    for (int i = 0; i < 8; i++) begin
      base = 32'h1000 + 32'(8 * i);
      drive(1'b1, 1'b1, base, base + 32'd4, 1'b0, 1'b0, 1'b0);
      if (i == 6) chk("fill14_full", {31'b0, fifo_full}, 32'd0);
    end
    chk("fill16_full", {31'b0, fifo_full}, 32'd1);
    drive(1'b1, 1'b1, 32'h2000, 32'h2004, 1'b0, 1'b0, 1'b0);
    chk("drop_full", {31'b0, fifo_full}, 32'd1);
    chk("drop_addr_1", read_addr_1, 32'h1000);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("count15_full", {31'b0, fifo_full}, 32'd1);
    chk("count15_addr_1", read_addr_1, 32'h1004);
    // Full at 15: writes dropped despite the dual pop -> 13 left.
    drive(1'b1, 1'b1, 32'h3000, 32'h3004, 1'b1, 1'b1, 1'b0);
    chk("count13_full", {31'b0, fifo_full}, 32'd0);
    chk("count13_addr_1", read_addr_1, 32'h100c);
    chk("count13_addr_2", read_addr_2, 32'h1010);

    // Drain to 6 then flush with simultaneous dual write and read.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("count6_addr_1", read_addr_1, 32'h1028);
    drive(1'b1, 1'b1, 32'h4000, 32'h4004, 1'b1, 1'b1, 1'b1);
    chk("flush_empty",   {31'b0, fifo_empty},   32'd1);
    chk("flush_valid_1", {31'b0, read_valid_1}, 32'd0);
    chk("flush_addr_1",  read_addr_1,           32'h0);

    // Wrap: 20 single writes at 0x0..0x4C, popping alongside from the 13th.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 32'(4 * i), 32'h0, (i >= 12), 1'b0, 1'b0);
    end
    for (int k = 8; k < 20; k++) begin
      chk("wrap_order", read_addr_1, 32'(4 * k));
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("wrap_drained", {31'b0, fifo_empty}, 32'd1);

    // Reset mid-operation discards entries; next write is the new head.
    drive(1'b1, 1'b1, 32'h5000, 32'h5004, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h5008, 32'h0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_empty", {31'b0, fifo_empty},   32'd1);
    chk("async_rst_valid", {31'b0, read_valid_1}, 32'd0);
    idle();
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h00000abc, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_addr_1", read_addr_1, 32'h00000abc);
    chk("post_rst_valid_2", {31'b0, read_valid_2}, 32'd0);

    // Randomised tail of mixed traffic for the model to police.
    for (int i = 0; i < 200; i++) begin
      base = 32'h8000_0000 + 32'(8 * i);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), base, base + 32'd4,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_fifo.md
INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 Parameter DEPTH, default 16, meaning entry count (power of two, >= 4).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  discard all entries (branch/exception redirect).
REQ-005 write_en_1  input  1  fetch lane 1 instruction valid (inst_ok_1 from PC stage).
REQ-006 write_en_2  input  1  fetch lane 2 instruction valid (inst_ok_2 from PC stage).
REQ-007 write_addr_1, write_addr_2  input  32 each  PC of lane 1 / lane 2 instruction.
REQ-008 write_data_1, write_data_2  input  32 each  instruction word of lane 1 / lane 2.
REQ-009 read_en_1  input  1  decode consumes head entry.
REQ-010 read_en_2  input  1  decode consumes second entry.
REQ-011 read_addr_1, read_addr_2  output  32 each  PC of head / head+1 entry.
REQ-012 read_data_1, read_data_2  output  32 each  instruction of head / head+1 entry.
REQ-013 read_valid_1, read_valid_2  output  1 each  head / head+1 entry present.
REQ-014 fifo_full  output  1  fewer than 2 free entries (to PC stage).
REQ-015 fifo_empty  output  1  zero entries held.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH entries of {addr[31:0], data[31:0]} with head pointer, tail pointer and count of width log2(DEPTH)+1.
REQ-017 Read outputs SHALL be first-word-fall-through: read_*_1 from entry[head], read_*_2 from entry[head+1 mod DEPTH], combinational from registered state.
REQ-018 read_valid_1 = (count >= 1); read_valid_2 = (count >= 2); fifo_empty = (count == 0); fifo_full = (count >= DEPTH-1); all derived from registered count only.
REQ-019 When read_valid_* is 0, the matching read_addr/read_data SHALL be 0.
REQ-020 Write acceptance: when fifo_full is 0 and flush is 0, write_en_1 alone writes lane 1 at tail (tail+1); write_en_1 and write_en_2 write lane 1 at tail, lane 2 at tail+1 (tail+2).
REQ-021 write_en_2 without write_en_1 SHALL be ignored (no entry written).
REQ-022 All writes presented while fifo_full is 1 SHALL be dropped, even if a read occurs in the same cycle.
REQ-023 Read acceptance: read_en_1 with read_valid_1 pops one; read_en_1 and read_en_2 with read_valid_2 pop two; read_en_2 without read_en_1, or requests exceeding read_valid, pop only what is both requested in order and valid.
REQ-024 Simultaneous read and write in one cycle SHALL both take effect; count_next = count + writes - reads.
REQ-025 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-026 flush SHALL have priority over all reads and writes: next cycle head = tail = count = 0; same-cycle writes dropped.
REQ-027 Latency: an entry written at edge N SHALL be visible on read outputs after edge N (same cycle as read_valid rises).

Reset
REQ-028 On rst low, asynchronously: head, tail, count = 0; fifo_empty = 1; fifo_full = 0; read_valid_* = 0; read_addr/data = 0.
REQ-029 Entry storage contents need not be reset.
REQ-030 Reset asserted mid-operation SHALL discard all entries; first write after rst rises SHALL land at index 0.

Verification
REQ-031 Reset then dual write {bfc00000,I0},{bfc00004,I1} -> next cycle read_valid_1=1, read_valid_2=1, read_addr_1=bfc00000, read_addr_2=bfc00004, fifo_empty=0.
REQ-032 Fill with 8 dual writes, DEPTH=16 -> fifo_full=1 when count=15 or 16; further writes dropped; count unchanged.
REQ-033 count=15, dual read + dual write same cycle -> writes dropped, count=13, fifo_full=0 next cycle.
REQ-034 Wrap: push/pop 20 single entries, addresses 0x0..0x4C -> read order matches write order across pointer wrap, no loss.
REQ-035 count=6, flush with dual write and dual read -> next cycle count=0, fifo_empty=1, read_valid_1=0.
REQ-036 count=1, read_en_1=read_en_2=1 -> one pop only, count=0; write_en_2 alone -> count stays 0.
